// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the sequential CR16-style ALU
//
// Purpose: opcode/opext constants, PSR flag indices, FSM state enum and the
// decoded-operation enum with the decode helper used by alu_seq.
// Ports: none (package).

package alu_seq_pkg;

  // Major opcodes. OP_REG selects the register form, which is qualified by opext.
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;

  // Register-form extensions.
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MUL  = 4'b1110;

  // PSR bit positions within CLFZN.
  localparam int C_IDX = 4;
  localparam int L_IDX = 3;
  localparam int F_IDX = 2;
  localparam int Z_IDX = 1;
  localparam int N_IDX = 0;

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [3:0] {
    DEC_ILL, DEC_ADD, DEC_ADDU, DEC_ADDC, DEC_SUB,
    DEC_CMP, DEC_AND, DEC_OR, DEC_XOR, DEC_MUL
  } dec_op_t;

  // Immediate forms ignore opext entirely.
  function automatic dec_op_t decode(input logic [3:0] opcode, input logic [3:0] opext);
    dec_op_t d;
    d = DEC_ILL;
    case (opcode)
      OP_REG: begin
        case (opext)
          EXT_AND:  d = DEC_AND;
          EXT_OR:   d = DEC_OR;
          EXT_XOR:  d = DEC_XOR;
          EXT_ADD:  d = DEC_ADD;
          EXT_ADDU: d = DEC_ADDU;
          EXT_ADDC: d = DEC_ADDC;
          EXT_SUB:  d = DEC_SUB;
          EXT_CMP:  d = DEC_CMP;
          EXT_MUL:  d = DEC_MUL;
          default:  d = DEC_ILL;
        endcase
      end
      OP_ADDI:  d = DEC_ADD;
      OP_ADDUI: d = DEC_ADDU;
      OP_ADDCI: d = DEC_ADDC;
      OP_SUBI:  d = DEC_SUB;
      OP_CMPI:  d = DEC_CMP;
      default:  d = DEC_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one step per cycle
//
// Purpose: low WIDTH bits of a*b, computed over STEPS cycles after start.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   start          latch a/b, clear accumulator, begin stepping
//   a, b           multiplicand, multiplier
//   done           high during the final step; product is valid in that cycle
//   product        accumulator including the current step's contribution

module alu_seq_mul #(
  parameter int WIDTH = 16,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(STEPS);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy;

  // Product is exposed combinationally so the owner can capture the
  // final step's result on the same edge that retires the operation.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered CR16-style ALU with PSR and iterative MUL
//
// Purpose: decodes one operation per accepted handshake, updates S and the
// persistent PSR {C,L,F,Z,N}; MUL runs multi-cycle in alu_seq_mul.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   in_valid, in_ready   operation handshake (in_ready high only in IDLE)
//   A, B                 operands
//   opcode, opext        CR16 major opcode / extension
//   out_valid            one-cycle pulse when S/CLFZN/illegal are valid
//   S, CLFZN, illegal    result, PSR flags, unsupported-op indicator

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic [4:0]       CLFZN,
  output logic             illegal
);

  state_t           state, next_state;
  dec_op_t          dec;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [4:0]       psr;

  logic             cin;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] s_next;
  logic [4:0]       flags_next;
  logic             ill_next;

  assign dec      = decode(opcode, opext);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign CLFZN    = psr;

  // ADDC sees the carry left by the previous op, so chained ADDCs propagate.
  assign cin     = (dec == DEC_ADDC) ? psr[C_IDX] : 1'b0;
  assign add_res = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign sub_res = {1'b0, A} - {1'b0, B};
  // Subtract overflow uses ~B's sign, i.e. operand signs must differ.
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && dec == DEC_MUL) begin
          next_state = MUL;
          mul_start  = 1'b1;
        end
      end
      MUL: begin
        if (mul_done) next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    s_next     = S;
    flags_next = psr;
    ill_next   = 1'b0;
    case (dec)
      DEC_ADD: begin
        s_next            = add_res[WIDTH-1:0];
        flags_next[F_IDX] = add_ovf;
        flags_next[Z_IDX] = (add_res[WIDTH-1:0] == '0);
      end
      DEC_ADDU: begin
        s_next            = add_res[WIDTH-1:0];
        flags_next[C_IDX] = add_res[WIDTH];
        flags_next[Z_IDX] = (add_res[WIDTH-1:0] == '0);
      end
      DEC_ADDC: begin
        s_next            = add_res[WIDTH-1:0];
        flags_next[C_IDX] = add_res[WIDTH];
        flags_next[F_IDX] = add_ovf;
        flags_next[Z_IDX] = (add_res[WIDTH-1:0] == '0);
      end
      DEC_SUB: begin
        s_next            = sub_res[WIDTH-1:0];
        flags_next[C_IDX] = sub_res[WIDTH];
        flags_next[F_IDX] = sub_ovf;
        flags_next[Z_IDX] = (sub_res[WIDTH-1:0] == '0);
      end
      DEC_CMP: begin
        flags_next[Z_IDX] = (A == B);
        flags_next[L_IDX] = (B < A);
        flags_next[N_IDX] = ($signed(B) < $signed(A));
      end
      DEC_AND: s_next = A & B;
      DEC_OR:  s_next = A | B;
      DEC_XOR: s_next = A ^ B;
      DEC_ILL: ill_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      S         <= '0;
      psr       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (accept && dec != DEC_MUL) begin
        S         <= s_next;
        psr       <= flags_next;
        out_valid <= 1'b1;
        illegal   <= ill_next;
      end else if (state == MUL && mul_done) begin
        S         <= mul_product;
        out_valid <= 1'b1;
      end
    end
  end

  alu_seq_mul #(
    .WIDTH (WIDTH),
    .STEPS (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule
